// File: rtl/lsb_embed_ctrl_pkg.sv
// Shared types and constants for the LSB embedding sequencer.
// Optional feature macro: LSB_EMBED_PARITY_EN adds an even-parity bit after each byte.
package lsb_embed_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        FULL = 3'd4
    } state_t;

    localparam int BITS_PER_BYTE  = 8;
    localparam int CYCLES_PER_BIT = 3;

`ifdef LSB_EMBED_PARITY_EN
    localparam int BITS_PER_FRAME = BITS_PER_BYTE + 1;
`else
    localparam int BITS_PER_FRAME = BITS_PER_BYTE;
`endif

    localparam int CYCLES_PER_FRAME = BITS_PER_FRAME * CYCLES_PER_BIT;

endpackage

// File: rtl/lsb_embed_ctrl_if.sv
// Message handshake and pixel-RAM bus bundle for the LSB embedding sequencer.
// master = the sequencer, slave = message source plus pixel RAM.
interface lsb_embed_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int PIX_W  = 8
);
    logic [7:0]        msg_data;
    logic              msg_valid;
    logic              msg_ready;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_rd_en;
    logic [PIX_W-1:0]  pix_rdata;
    logic              pix_wr_en;
    logic [PIX_W-1:0]  pix_wdata;

    modport master (
        input  msg_data, msg_valid, pix_rdata,
        output msg_ready, pix_addr, pix_rd_en, pix_wr_en, pix_wdata
    );

    modport slave (
        output msg_data, msg_valid, pix_rdata,
        input  msg_ready, pix_addr, pix_rd_en, pix_wr_en, pix_wdata
    );
endinterface

// File: rtl/lsb_embed_ctrl_serializer.sv
// lsb_bit_serializer: holds the accepted byte and walks it MSB-first.
// With LSB_EMBED_PARITY_EN defined, an even-parity bit follows bit 0.
module lsb_bit_serializer
    import lsb_embed_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_i,
    input  logic                     advance_i,
    input  logic [BITS_PER_BYTE-1:0] data_i,
    output logic                     cur_bit_o,
    output logic                     last_bit_o
);

    logic [BITS_PER_BYTE-1:0] shreg_q, shreg_d;
    logic [2:0]               bit_idx_q, bit_idx_d;

`ifdef LSB_EMBED_PARITY_EN
    logic par_phase_q, par_phase_d;

    // Load a new byte or step to the next bit; parity phase follows bit 0
    always_comb begin
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        par_phase_d = par_phase_q;
        if (load_i) begin
            shreg_d     = data_i;
            bit_idx_d   = 3'd7;
            par_phase_d = 1'b0;
        end else if (advance_i) begin
            if (bit_idx_q == 3'd0) begin
                par_phase_d = 1'b1;
            end else begin
                bit_idx_d = bit_idx_q - 3'd1;
            end
        end
    end

    // Parity phase register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_phase_q <= 1'b0;
        end else begin
            par_phase_q <= par_phase_d;
        end
    end

    assign cur_bit_o  = par_phase_q ? (^shreg_q) : shreg_q[bit_idx_q];
    assign last_bit_o = par_phase_q;
`else
    // Load a new byte or step to the next lower bit
    always_comb begin
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        if (load_i) begin
            shreg_d   = data_i;
            bit_idx_d = 3'd7;
        end else if (advance_i && (bit_idx_q != 3'd0)) begin
            bit_idx_d = bit_idx_q - 3'd1;
        end
    end

    assign cur_bit_o  = shreg_q[bit_idx_q];
    assign last_bit_o = (bit_idx_q == 3'd0);
`endif

    // Byte latch and bit index registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '0;
            bit_idx_q <= 3'd7;
        end else begin
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
        end
    end

endmodule

// File: rtl/lsb_embed_ctrl.sv
// lsb_embed_ctrl: serialises message bytes into the LSBs of cover pixels via
// read-modify-write (RD -> CAP -> WR per bit) and tracks image capacity.
// Optional macro LSB_EMBED_PARITY_EN (handled in the serializer) appends an
// even-parity pixel to every byte. HRESETn is an active-high async reset.
module lsb_embed_ctrl
    import lsb_embed_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int NUM_PIXELS = 1024,
    parameter int PIX_W      = 8
) (
    input  logic             clk,
    input  logic             HRESETn,
    input  logic             embed_en,
    input  logic             clr,
    lsb_embed_ctrl_if.master bus,
    output logic             byte_done,
    output logic             full_flag,
    output logic             truncated
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] hold_q, hold_d;
    logic [PIX_W-1:0]  cap_q, cap_d;
    logic              full_q, full_d;
    logic              trunc_q, trunc_d;
    logic              cur_bit, last_bit;
    logic              at_last, rdy, accept, ser_adv;

    assign at_last = (addr_q == LAST_ADDR);
    // Ready is held low while reset is asserted, even though state is IDLE
    assign rdy     = (state_q == IDLE) && embed_en && !full_q && !HRESETn;
    assign accept  = rdy && bus.msg_valid;
    assign ser_adv = (state_q == WR) && !at_last && !last_bit;

    lsb_bit_serializer u_ser (
        .clk        (clk),
        .rst        (HRESETn),
        .load_i     (accept),
        .advance_i  (ser_adv),
        .data_i     (bus.msg_data),
        .cur_bit_o  (cur_bit),
        .last_bit_o (last_bit)
    );

    // State register
    always_ff @(posedge clk or posedge HRESETn) begin
        if (HRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus address, capture and flag updates
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        cap_d   = cap_q;
        full_d  = full_q;
        trunc_d = trunc_q;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    addr_d = '0;
                end
                if (accept) begin
                    state_d = RD;
                end
            end
            RD: begin
                hold_d  = addr_q;
                state_d = CAP;
            end
            CAP: begin
                cap_d   = bus.pix_rdata;
                state_d = WR;
            end
            WR: begin
                hold_d = addr_q;
                addr_d = addr_q + ADDR_W'(1);
                if (at_last) begin
                    state_d = FULL;
                    full_d  = 1'b1;
                    trunc_d = !last_bit;
                end else if (last_bit) begin
                    state_d = IDLE;
                end else begin
                    state_d = RD;
                end
            end
            FULL: begin
                if (clr) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    full_d  = 1'b0;
                    trunc_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes, bus address/data and completion pulse decoded from state
    always_comb begin
        bus.msg_ready = rdy;
        bus.pix_rd_en = (state_q == RD);
        bus.pix_wr_en = (state_q == WR);
        bus.pix_addr  = ((state_q == RD) || (state_q == WR)) ? addr_q : hold_q;
        bus.pix_wdata = '0;
        byte_done     = 1'b0;
        if (state_q == WR) begin
            bus.pix_wdata = (cap_q & ~PIX_W'(1)) | PIX_W'(cur_bit);
            byte_done     = last_bit && !at_last;
        end
    end

    // Address, held bus address, captured pixel and status flags
    always_ff @(posedge clk or posedge HRESETn) begin
        if (HRESETn) begin
            addr_q  <= '0;
            hold_q  <= '0;
            cap_q   <= '0;
            full_q  <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            cap_q   <= cap_d;
            full_q  <= full_d;
            trunc_q <= trunc_d;
        end
    end

    assign full_flag = full_q;
    assign truncated = trunc_q;

endmodule

// File: doc/lsb_embed_ctrl.md
Name: lsb_embed_ctrl

Overview:
Sequencer for the LSB steganography datapath. It accepts secret-message bytes through a valid/ready handshake and serialises each byte MSB-first. For every message bit it performs a read-modify-write on one cover-image pixel in the pixel memory, replacing that pixel's LSB with the bit. It sits between the message source and the cover/stego pixel RAM, tracks image capacity and raises full_flag when the image is exhausted.

Parameters:
ADDR_W, 10, pixel address width
NUM_PIXELS, 1024, cover image capacity in pixels (1 to 2**ADDR_W)
PIX_W, 8, pixel width in bits

Ports:
clk  in  1  system clock, all logic on rising edge
HRESETn  in  1  asynchronous reset, ACTIVE-HIGH despite the codebase name; asserting it clears all state immediately
embed_en  in  1  permits acceptance of new message bytes; does not abort a byte in progress
clr  in  1  synchronous pulse; clears full_flag, truncated and the pixel address; ignored unless state is IDLE or FULL
msg_data  in  8  secret message byte
msg_valid  in  1  msg_data valid
msg_ready  out  1  controller can accept a byte
pix_addr  out  ADDR_W  pixel memory address
pix_rd_en  out  1  pixel read strobe; synchronous RAM, data returns next cycle
pix_rdata  in  PIX_W  pixel read data
pix_wr_en  out  1  pixel write strobe
pix_wdata  out  PIX_W  stego pixel to write
byte_done  out  1  one-cycle pulse when the last bit of a byte is written
full_flag  out  1  image capacity exhausted
truncated  out  1  a byte was cut short by capacity exhaustion

Behaviour:
- Reset: state IDLE, address=0, bit_idx=7.
- Output reset values: msg_ready=0 during reset and =1 on the first cycle after reset if embed_en. All other outputs are 0.
- States: IDLE, RD, CAP, WR, FULL.
- IDLE: msg_ready = embed_en & ~full_flag. On msg_valid & msg_ready: latch msg_data into shreg, set bit_idx=7, go to RD.
- RD: pix_rd_en=1, pix_addr=addr. Go to CAP.
- CAP: register pix_rdata. Go to WR.
- WR: pix_wr_en=1, pix_addr=addr, pix_wdata = {captured[PIX_W-1:1], shreg[bit_idx]}. Then addr <= addr+1.
  - If addr == NUM_PIXELS-1: go to FULL and set full_flag. If bit_idx != 0, also set truncated; byte_done does not pulse.
  - Else if bit_idx == 0: pulse byte_done and go to IDLE.
  - Else: bit_idx--, go to RD.
- Timing: 3 cycles per bit, 24 cycles per byte from handshake to byte_done. Next byte can be accepted the cycle after byte_done.
- pix_addr holds its value outside RD/WR. pix_rd_en and pix_wr_en are never both 1 in the same cycle.
- FULL: msg_ready=0, strobes 0. clr returns to IDLE with addr=0 and flags cleared.
- clr in IDLE resets addr to 0. clr in RD/CAP/WR is ignored.
- embed_en falling mid-byte: the byte completes; only new acceptance is blocked.
- HRESETn mid-byte: the in-flight byte is abandoned; the partially written pixel stays as written.
- NUM_PIXELS=1: the first WR goes straight to FULL with truncated=1.

Optional Feature:
LSB_EMBED_PARITY_EN. When defined, each byte is followed by a ninth embedded bit: even parity (XOR of the 8 data bits). The ninth pixel is written, then byte_done pulses, giving 27 cycles per byte; truncated also covers a missing parity pixel. When undefined, 8 bits per byte and no parity logic.

Decomposition:
- Package lsb_embed_pkg holds the state enum (IDLE, RD, CAP, WR, FULL), BITS_PER_BYTE=8, and the 3-cycle-per-bit constant.
- Sub-module lsb_bit_serializer: byte latch, bit_idx counter and optional parity bit, exposing cur_bit/last_bit. The FSM and address counter stay in the top.

Test Plan:
- Pixel RAM preset to 0xFF; send 0x48 ('H') -> writes to addr 0..7 = FE,FF,FE,FE,FF,FE,FE,FE; byte_done exactly 24 cycles after the handshake.
- Back-to-back bytes "Hello" (0x48,0x65,0x6C,0x6C,0x6F) with msg_valid held -> 40 pixel writes at addr 0..39, 5 byte_done pulses, LSBs of addr 0..39 read back as the message bits.
- NUM_PIXELS=12, send 0x48 then 0x65 -> second byte stops after 4 bits (addr 8..11); full_flag=1, truncated=1, msg_ready=0, no second byte_done. Pulse clr -> full_flag=0, next write at addr 0.
- Assert HRESETn at cycle 10 of a byte -> all outputs 0 immediately. After release, the next byte writes from addr 0.
- embed_en dropped 5 cycles into a byte -> the byte completes with byte_done; msg_ready stays 0 while embed_en=0.
- With LSB_EMBED_PARITY_EN: send 0x48 (parity 0) into all-0xFF RAM -> addr 8 written 0xFE, byte_done at cycle 27.
